// File: rtl/register_sequencer.sv
// register_sequencer: drives a byte-level I2C master through single-byte
// register writes and reads. Adds whole-access retry on NACK or bus error
// and a per-byte watchdog.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a command (cmd_ready high)
// WAIT_BUS  | attempt pending, waiting for the master bus to go idle
// BYTE      | one byte in flight, request lines for the next step presented
// STOP      | requests dropped, waiting for the master to finish STOP
// BACKOFF   | idle gap before the whole access is retried
// RESP      | one-cycle response pulse
module register_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned BACKOFF_CYCLES = 1000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [1:0] rsp_status,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_retries,
  output logic       m_mode,
  output logic       m_transfer_start,
  output logic       m_transfer_continue,
  output logic [7:0] m_data_tx,
  input  logic       m_transaction_ready,
  input  logic       m_transaction_complete,
  input  logic       m_ack,
  input  logic       m_start_err,
  input  logic       m_arbitration_err,
  input  logic [7:0] m_data_rx,
  input  logic       m_data_rx_enable
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BUS, S_BYTE, S_STOP, S_BACKOFF, S_RESP
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BUS     = 2'b11;

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam int unsigned BO_W = $clog2(BACKOFF_CYCLES + 2);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BACKOFF_CYCLES);
  localparam logic [BO_W-1:0] BO_ONE  = BO_W'(1);
  localparam logic [7:0]      RETRY_MAX = 8'(MAX_RETRIES);

  state_t          state_q, state_d;
  logic            is_read_q, is_read_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [1:0]      byte_q, byte_d;
  logic [1:0]      status_q, status_d;
  logic            nack_q, nack_d;
  logic [7:0]      retry_q, retry_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [BO_W-1:0] bo_q, bo_d;
  logic            mode_q, mode_d;
  logic            start_q, start_d;
  logic            cont_q, cont_d;
  logic [7:0]      tx_q, tx_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_retries_q, rsp_retries_d;

  logic       bus_err, wd_active, wd_expire, tx_nack, is_last, to_stop, to_resp;
  logic [1:0] byte_nx, fin_status;

  // Byte b on the wire: 0 dev+W, 1 reg, 2 wdata or dev+R, 3 received data.
  function automatic logic [7:0] byte_data(input logic [1:0] b, input logic rd,
                                           input logic [6:0] dev, input logic [7:0] ra,
                                           input logic [7:0] wd);
    case (b)
      2'd0:    return {dev, 1'b0};
      2'd1:    return ra;
      2'd2:    return rd ? {dev, 1'b1} : wd;
      default: return 8'h00;
    endcase
  endfunction

  // Request lines {start, continue} that follow byte b; 00 means STOP.
  function automatic logic [1:0] step_req(input logic [1:0] b, input logic rd);
    case (b)
      2'd0:    return 2'b01;
      2'd1:    return rd ? 2'b10 : 2'b01;
      2'd2:    return rd ? 2'b01 : 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d       = state_q;
    is_read_d     = is_read_q;
    dev_d         = dev_q;
    reg_d         = reg_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    byte_d        = byte_q;
    status_d      = status_q;
    nack_d        = nack_q;
    retry_d       = retry_q;
    bo_d          = bo_q;
    mode_d        = mode_q;
    start_d       = start_q;
    cont_d        = cont_q;
    tx_d          = tx_q;
    rsp_valid_d   = 1'b0;
    rsp_status_d  = rsp_status_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_retries_d = rsp_retries_q;

    bus_err    = m_start_err | m_arbitration_err;
    wd_active  = (state_q == S_WAIT_BUS) || (state_q == S_BYTE) || (state_q == S_STOP);
    wd_expire  = wd_active && (wd_q <= WD_ONE);
    wd_d       = wd_active ? (wd_q - WD_ONE) : wd_q;
    tx_nack    = m_ack && (byte_q != 2'd3);
    is_last    = is_read_q ? (byte_q == 2'd3) : (byte_q == 2'd2);
    byte_nx    = byte_q + 2'd1;
    to_stop    = 1'b0;
    to_resp    = 1'b0;
    fin_status = status_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          is_read_d = cmd_read;
          dev_d     = cmd_dev_addr;
          reg_d     = cmd_reg_addr;
          wdata_d   = cmd_wdata;
          retry_d   = 8'd0;
          byte_d    = 2'd0;
          nack_d    = 1'b0;
          status_d  = ST_OK;
          rdata_d   = 8'h00;
          wd_d      = WD_LOAD;
          state_d   = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (bus_err) begin
          status_d = ST_BUS;
          to_stop  = 1'b1;
        end else if (wd_expire) begin
          status_d = ST_TIMEOUT;
          to_stop  = 1'b1;
        end else if (m_transaction_ready) begin
          start_d = 1'b1;
          cont_d  = 1'b0;
          mode_d  = 1'b0;
          tx_d    = byte_data(2'd0, is_read_q, dev_q, reg_q, wdata_q);
          state_d = S_BYTE;
        end
      end
      S_BYTE: begin
        // The START pulse from WAIT_BUS gives way to the lines for the next step.
        {start_d, cont_d} = step_req(byte_q, is_read_q);
        if (tx_nack) nack_d = 1'b1;
        if (m_data_rx_enable && (byte_q == 2'd3)) rdata_d = m_data_rx;
        if (bus_err) begin
          status_d = ST_BUS;
          to_stop  = 1'b1;
        end else if (wd_expire) begin
          status_d = ST_TIMEOUT;
          to_stop  = 1'b1;
        end else if (m_transaction_complete) begin
          if (nack_q || tx_nack) begin
            status_d = ST_NACK;
            to_stop  = 1'b1;
          end else if (is_last) begin
            to_stop = 1'b1;
          end else begin
            byte_d            = byte_nx;
            mode_d            = (byte_nx == 2'd3);
            tx_d              = byte_data(byte_nx, is_read_q, dev_q, reg_q, wdata_q);
            {start_d, cont_d} = step_req(byte_nx, is_read_q);
            wd_d              = WD_LOAD;
          end
        end
      end
      S_STOP: begin
        if (m_transaction_ready) begin
          if (((status_q == ST_NACK) || (status_q == ST_BUS)) && (retry_q < RETRY_MAX)) begin
            retry_d = retry_q + 8'd1;
            bo_d    = BO_LOAD;
            state_d = S_BACKOFF;
          end else begin
            to_resp = 1'b1;
          end
        end else if (wd_expire) begin
          fin_status = ST_TIMEOUT;
          to_resp    = 1'b1;
        end
      end
      S_BACKOFF: begin
        bo_d = bo_q - BO_ONE;
        if (bo_q <= BO_ONE) begin
          byte_d   = 2'd0;
          nack_d   = 1'b0;
          status_d = ST_OK;
          rdata_d  = 8'h00;
          wd_d     = WD_LOAD;
          state_d  = S_WAIT_BUS;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // STOP gets a fresh watchdog window so a master stuck in STOP is still bounded.
    if (to_stop) begin
      state_d = S_STOP;
      start_d = 1'b0;
      cont_d  = 1'b0;
      mode_d  = 1'b0;
      tx_d    = 8'h00;
      wd_d    = WD_LOAD;
    end
    if (to_resp) begin
      state_d       = S_RESP;
      status_d      = fin_status;
      rsp_valid_d   = 1'b1;
      rsp_status_d  = fin_status;
      rsp_rdata_d   = (is_read_q && (fin_status == ST_OK)) ? rdata_q : 8'h00;
      rsp_retries_d = (retry_q > 8'd3) ? 2'd3 : retry_q[1:0];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= S_IDLE;
      is_read_q     <= 1'b0;
      dev_q         <= 7'h00;
      reg_q         <= 8'h00;
      wdata_q       <= 8'h00;
      rdata_q       <= 8'h00;
      byte_q        <= 2'd0;
      status_q      <= ST_OK;
      nack_q        <= 1'b0;
      retry_q       <= 8'd0;
      wd_q          <= '0;
      bo_q          <= '0;
      mode_q        <= 1'b0;
      start_q       <= 1'b0;
      cont_q        <= 1'b0;
      tx_q          <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= ST_OK;
      rsp_rdata_q   <= 8'h00;
      rsp_retries_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      is_read_q     <= is_read_d;
      dev_q         <= dev_d;
      reg_q         <= reg_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      byte_q        <= byte_d;
      status_q      <= status_d;
      nack_q        <= nack_d;
      retry_q       <= retry_d;
      wd_q          <= wd_d;
      bo_q          <= bo_d;
      mode_q        <= mode_d;
      start_q       <= start_d;
      cont_q        <= cont_d;
      tx_q          <= tx_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_retries_q <= rsp_retries_d;
    end
  end

  assign cmd_ready           = (state_q == S_IDLE);
  assign rsp_valid           = rsp_valid_q;
  assign rsp_status          = rsp_status_q;
  assign rsp_rdata           = rsp_rdata_q;
  assign rsp_retries         = rsp_retries_q;
  assign m_mode              = mode_q;
  assign m_transfer_start    = start_q;
  assign m_transfer_continue = cont_q;
  assign m_data_tx           = tx_q;

endmodule

// File: tb/tb_register_sequencer.sv
// Directed bench for register_sequencer: write, read, NACK retry, timeout,
// arbitration loss (no-retry instance) and reset mid-access.
module tb_register_sequencer;
  localparam int T_CYC = 200;
  localparam int B_CYC = 20;

  logic clk_in;
  logic reset;
  logic cmd_valid_a, cmd_valid_b;
  logic cmd_read;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr, cmd_wdata;
  logic m_transaction_ready, m_transaction_complete, m_ack;
  logic m_start_err, m_arbitration_err, m_data_rx_enable;
  logic [7:0] m_data_rx;

  logic       cmd_ready_a, rsp_valid_a, m_mode_a, start_a, cont_a;
  logic [1:0] rsp_status_a, rsp_retries_a;
  logic [7:0] rsp_rdata_a, data_tx_a;
  logic       cmd_ready_b, rsp_valid_b, m_mode_b, start_b, cont_b;
  logic [1:0] rsp_status_b, rsp_retries_b;
  logic [7:0] rsp_rdata_b, data_tx_b;

  logic       sel;
  logic       o_cmd_ready, o_rsp_valid, o_mode, o_start, o_cont;
  logic [1:0] o_rsp_status, o_rsp_retries;
  logic [7:0] o_rsp_rdata, o_data_tx;

  int checks = 0;
  int errors = 0;
  int n;

  register_sequencer #(.TIMEOUT_CYCLES(T_CYC), .MAX_RETRIES(3), .BACKOFF_CYCLES(B_CYC)) u_dut (
    .clk_in(clk_in), .reset(reset),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_read(cmd_read),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_a), .rsp_status(rsp_status_a), .rsp_rdata(rsp_rdata_a),
    .rsp_retries(rsp_retries_a), .m_mode(m_mode_a), .m_transfer_start(start_a),
    .m_transfer_continue(cont_a), .m_data_tx(data_tx_a),
    .m_transaction_ready(m_transaction_ready), .m_transaction_complete(m_transaction_complete),
    .m_ack(m_ack), .m_start_err(m_start_err), .m_arbitration_err(m_arbitration_err),
    .m_data_rx(m_data_rx), .m_data_rx_enable(m_data_rx_enable)
  );

  register_sequencer #(.TIMEOUT_CYCLES(T_CYC), .MAX_RETRIES(0), .BACKOFF_CYCLES(B_CYC)) u_dut0 (
    .clk_in(clk_in), .reset(reset),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_read(cmd_read),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_b), .rsp_status(rsp_status_b), .rsp_rdata(rsp_rdata_b),
    .rsp_retries(rsp_retries_b), .m_mode(m_mode_b), .m_transfer_start(start_b),
    .m_transfer_continue(cont_b), .m_data_tx(data_tx_b),
    .m_transaction_ready(m_transaction_ready), .m_transaction_complete(m_transaction_complete),
    .m_ack(m_ack), .m_start_err(m_start_err), .m_arbitration_err(m_arbitration_err),
    .m_data_rx(m_data_rx), .m_data_rx_enable(m_data_rx_enable)
  );

  assign o_cmd_ready   = sel ? cmd_ready_b   : cmd_ready_a;
  assign o_rsp_valid   = sel ? rsp_valid_b   : rsp_valid_a;
  assign o_rsp_status  = sel ? rsp_status_b  : rsp_status_a;
  assign o_rsp_rdata   = sel ? rsp_rdata_b   : rsp_rdata_a;
  assign o_rsp_retries = sel ? rsp_retries_b : rsp_retries_a;
  assign o_mode        = sel ? m_mode_b      : m_mode_a;
  assign o_start       = sel ? start_b       : start_a;
  assign o_cont        = sel ? cont_b        : cont_a;
  assign o_data_tx     = sel ? data_tx_b     : data_tx_a;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL global_timeout: summary not reached in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_cmd(input logic which, input logic rd, input logic [6:0] dev,
                          input logic [7:0] ra, input logic [7:0] wd);
    sel = which;
    chk("cmd_ready_idle", o_cmd_ready, 1);
    cmd_read = rd; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_wdata = wd;
    if (which) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    tick();
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_read = ~rd; cmd_dev_addr = 7'h7F; cmd_reg_addr = 8'hFF; cmd_wdata = 8'h00;
  endtask

  task automatic wait_start(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!o_start && cnt < 4 * T_CYC);
    chk("start_seen", o_start, 1);
  endtask

  task automatic run_byte(input string tag, input logic [7:0] tx, input logic mode,
                          input logic st, input logic ct, input logic ack,
                          input logic rx_en, input logic [7:0] rx);
    tick();
    chk({tag, "_tx"}, o_data_tx, tx);
    chk({tag, "_mode"}, o_mode, mode);
    chk({tag, "_start"}, o_start, st);
    chk({tag, "_cont"}, o_cont, ct);
    if (ack) begin
      m_ack = 1'b1; tick(); m_ack = 1'b0;
    end
    if (rx_en) begin
      m_data_rx = rx; m_data_rx_enable = 1'b1; tick(); m_data_rx_enable = 1'b0;
    end
    m_transaction_complete = 1'b1;
    tick();
    m_transaction_complete = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] st, input logic [7:0] rd,
                          input logic [1:0] rt);
    int cnt;
    cnt = 0;
    while (!o_rsp_valid && cnt < 4 * T_CYC) begin
      tick();
      cnt++;
    end
    chk({tag, "_rsp_valid"}, o_rsp_valid, 1);
    chk({tag, "_rsp_status"}, o_rsp_status, st);
    chk({tag, "_rsp_rdata"}, o_rsp_rdata, rd);
    chk({tag, "_rsp_retries"}, o_rsp_retries, rt);
    tick();
    chk({tag, "_rsp_one_cycle"}, o_rsp_valid, 0);
    chk({tag, "_cmd_ready_back"}, o_cmd_ready, 1);
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; cmd_read = 1'b0;
    cmd_dev_addr = 7'h00; cmd_reg_addr = 8'h00; cmd_wdata = 8'h00;
    m_transaction_ready = 1'b1; m_transaction_complete = 1'b0; m_ack = 1'b0;
    m_start_err = 1'b0; m_arbitration_err = 1'b0; m_data_rx = 8'h00; m_data_rx_enable = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_status", o_rsp_status, 0);
    chk("rst_rsp_rdata", o_rsp_rdata, 0);
    chk("rst_rsp_retries", o_rsp_retries, 0);
    chk("rst_start", o_start, 0);
    chk("rst_cont", o_cont, 0);
    chk("rst_mode", o_mode, 0);
    chk("rst_data_tx", o_data_tx, 0);

    // Register write: A0, 10, A5, STOP.
    send_cmd(1'b0, 1'b0, 7'h50, 8'h10, 8'hA5);
    wait_start(n);
    chk("wr_latency", n, 1);
    chk("wr_first_tx", o_data_tx, 8'hA0);
    chk("wr_first_cont", o_cont, 0);
    m_transaction_ready = 1'b0;
    run_byte("wr_b0", 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_byte("wr_b1", 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_byte("wr_b2", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("wr_stop_lines", {o_start, o_cont}, 2'b00);
    m_transaction_ready = 1'b1;
    wait_rsp("wr", 2'b00, 8'h00, 2'd0);

    // Register read: A0, 22, repeated START, A1, data 3C NACKed (m_ack there ignored).
    send_cmd(1'b0, 1'b1, 7'h50, 8'h22, 8'h00);
    wait_start(n);
    chk("rd_latency", n, 1);
    m_transaction_ready = 1'b0;
    run_byte("rd_b0", 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_byte("rd_b1", 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_byte("rd_b2", 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_byte("rd_b3", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
    chk("rd_stop_lines", {o_start, o_cont}, 2'b00);
    m_transaction_ready = 1'b1;
    wait_rsp("rd", 2'b00, 8'h3C, 2'd0);

    // NACK on the device byte every attempt: four STARTs, then status 01.
    send_cmd(1'b0, 1'b0, 7'h50, 8'h10, 8'hA5);
    for (int a = 0; a < 4; a++) begin
      wait_start(n);
      if (a == 0) chk("nk_first_latency", n, 1);
      else chk("nk_backoff_gap", (n >= B_CYC), 1);
      m_transaction_ready = 1'b0;
      run_byte("nk_b0", 8'hA0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("nk_drop", {o_start, o_cont}, 2'b00);
      m_transaction_ready = 1'b1;
    end
    wait_rsp("nk", 2'b01, 8'h00, 2'd3);

    // NACK on the first attempt only: retry completes normally.
    send_cmd(1'b0, 1'b0, 7'h50, 8'h10, 8'hA5);
    wait_start(n);
    m_transaction_ready = 1'b0;
    run_byte("n1_b0", 8'hA0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    m_transaction_ready = 1'b1;
    wait_start(n);
    chk("n1_backoff_gap", (n >= B_CYC), 1);
    m_transaction_ready = 1'b0;
    run_byte("n1_r_b0", 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_byte("n1_r_b1", 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_byte("n1_r_b2", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    m_transaction_ready = 1'b1;
    wait_rsp("n1", 2'b00, 8'h00, 2'd1);

    // Slave stretches forever: no complete, watchdog fires, no retry.
    send_cmd(1'b0, 1'b0, 7'h50, 8'h10, 8'hA5);
    wait_start(n);
    m_transaction_ready = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while ((o_start || o_cont) && n < 4 * T_CYC);
    chk("to_cycles_to_drop", n, T_CYC - 1);
    chk("to_busy_in_stop", o_cmd_ready, 0);
    m_transaction_ready = 1'b1;
    wait_rsp("to", 2'b10, 8'h00, 2'd0);

    // Arbitration lost during byte 1 on the no-retry instance.
    send_cmd(1'b1, 1'b0, 7'h50, 8'h10, 8'hA5);
    wait_start(n);
    m_transaction_ready = 1'b0;
    run_byte("ar_b0", 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    chk("ar_b1_cont", o_cont, 1);
    m_arbitration_err = 1'b1;
    tick();
    m_arbitration_err = 1'b0;
    chk("ar_drop", {o_start, o_cont}, 2'b00);
    m_transaction_ready = 1'b1;
    wait_rsp("ar", 2'b11, 8'h00, 2'd0);

    // Reset while byte 2 is in flight: lines drop, no response.
    send_cmd(1'b0, 1'b0, 7'h50, 8'h10, 8'hA5);
    wait_start(n);
    m_transaction_ready = 1'b0;
    run_byte("rs_b0", 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_byte("rs_b1", 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("rs_in_b2_tx", o_data_tx, 8'hA5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_lines", {o_start, o_cont}, 2'b00);
    chk("rs_cmd_ready", o_cmd_ready, 1);
    chk("rs_data_tx", o_data_tx, 0);
    m_transaction_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("rs_no_rsp", o_rsp_valid, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
